// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-style display model on the LCD bus.
// Decodes 8-bit and 4-bit (nibble pair) transfers and executes the init/text
// command subset. It holds 2 x 40 bytes of DDRAM, answers busy/address and
// data reads, and exports the first LINE_LENGTH characters of each line.
//
// Ports:
//   CLK, RESET_N          clock, async active-low reset
//   LCD_E/RS/RW/D_IN      bus inputs, synchronous to CLK
//   LCD_D_OUT, LCD_D_OE   read nibble and its drive enable
//   busy                  busy flag (execution counter running)
//   mode4bit, display_on  interface width and display-control D bit
//   cmd_strobe            one-cycle pulse per accepted write byte
//   protocol_err          sticky: write while busy, or RS/RW mismatch in a nibble pair
//   line1, line2          visible text, first char in the top byte [8*LINE_LENGTH -: 8]
module lcd_bus_responder #(
    parameter int LINE_LENGTH  = 16,
    parameter int EXEC_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 80000
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   LCD_E,
    input  logic                   LCD_RS,
    input  logic                   LCD_RW,
    input  logic [3:0]             LCD_D_IN,
    output logic [3:0]             LCD_D_OUT,
    output logic                   LCD_D_OE,
    output logic                   busy,
    output logic                   mode4bit,
    output logic                   display_on,
    output logic                   cmd_strobe,
    output logic                   protocol_err,
    output logic [8*LINE_LENGTH:1] line1,
    output logic [8*LINE_LENGTH:1] line2
);
    localparam int CNT_MAX    = (CLEAR_CYCLES > EXEC_CYCLES) ? CLEAR_CYCLES : EXEC_CYCLES;
    localparam int CW         = $clog2(CNT_MAX + 1);
    localparam int LINE_BYTES = 40;
    localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYCLES);
    localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_CYCLES);
    localparam logic [7:0]    SPACE    = 8'h20;

    typedef struct packed {
        logic       vld;
        logic       rs;
        logic [7:0] data;
    } wr_byte_t;

    logic          e_q;
    logic          rise;
    logic          fall;
    logic          ptr_low;      // 4-bit mode: next nibble is the low half
    logic [3:0]    hi_nib;
    logic          hi_rs;
    logic          hi_rw;
    logic [6:0]    addr;
    logic          incr;
    logic [CW-1:0] cnt;
    logic [7:0]    ddram [0:2*LINE_BYTES-1];

    wr_byte_t   wr;
    logic       pair_err;
    logic       rd_last;         // fall that completes a read (last nibble)
    logic       accept;
    logic [7:0] rd_byte;

    // Line 1 lives at 0x00-0x27, line 2 at 0x40-0x67; everything else is a gap.
    function automatic logic ram_hit(input logic [6:0] a);
        return a[5:0] < 6'd40;
    endfunction

    function automatic logic [6:0] ram_idx(input logic [6:0] a);
        return a[6] ? ({1'b0, a[5:0]} + 7'd40) : {1'b0, a[5:0]};
    endfunction

    // Address step wraps between the two line windows rather than through the gap.
    function automatic logic [6:0] next_addr(input logic [6:0] a, input logic up);
        if (up) begin
            if (a == 7'h27)      return 7'h40;
            else if (a == 7'h67) return 7'h00;
            else                 return a + 7'd1;
        end else begin
            if (a == 7'h00)      return 7'h67;
            else if (a == 7'h40) return 7'h27;
            else                 return a - 7'd1;
        end
    endfunction

    assign rise = LCD_E & ~e_q;
    assign fall = ~LCD_E & e_q;
    assign busy = (cnt != '0);

    always_comb begin
        wr       = '0;
        pair_err = 1'b0;
        rd_last  = 1'b0;
        if (fall) begin
            if (!mode4bit) begin
                wr.vld  = ~LCD_RW;
                wr.rs   = LCD_RS;
                wr.data = {LCD_D_IN, 4'h0};
                rd_last = LCD_RW;
            end else if (ptr_low) begin
                if (LCD_RS != hi_rs || LCD_RW != hi_rw) begin
                    // a pair of reads never flags an error, even if mismatched
                    pair_err = ~(LCD_RW & hi_rw);
                end else if (!LCD_RW) begin
                    wr.vld  = 1'b1;
                    wr.rs   = LCD_RS;
                    wr.data = {hi_nib, LCD_D_IN};
                end else begin
                    rd_last = 1'b1;
                end
            end
        end
    end

    // busy is the registered counter state, so a byte completing on the cycle
    // the counter hits zero is still refused.
    assign accept = wr.vld & ~busy;

    always_comb begin
        rd_byte = {busy, addr};
        if (LCD_RS) rd_byte = ram_hit(addr) ? ddram[ram_idx(addr)] : SPACE;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            e_q          <= 1'b0;
            ptr_low      <= 1'b0;
            hi_nib       <= 4'h0;
            hi_rs        <= 1'b0;
            hi_rw        <= 1'b0;
            addr         <= 7'h00;
            incr         <= 1'b1;
            cnt          <= '0;
            mode4bit     <= 1'b0;
            display_on   <= 1'b0;
            cmd_strobe   <= 1'b0;
            protocol_err <= 1'b0;
            LCD_D_OUT    <= 4'h0;
            LCD_D_OE     <= 1'b0;
            for (int i = 0; i < 2*LINE_BYTES; i++) ddram[i] <= SPACE;
        end else begin
            e_q        <= LCD_E;
            cmd_strobe <= accept;

            if (cnt != '0) cnt <= cnt - CW'(1);

            if (pair_err || (wr.vld && busy)) protocol_err <= 1'b1;

            // Reads and writes share the nibble pointer.
            if (fall && mode4bit) begin
                ptr_low <= ~ptr_low;
                if (!ptr_low) begin
                    hi_nib <= LCD_D_IN;
                    hi_rs  <= LCD_RS;
                    hi_rw  <= LCD_RW;
                end
            end

            if (rise && LCD_RW) begin
                LCD_D_OE  <= 1'b1;
                LCD_D_OUT <= (mode4bit && ptr_low) ? rd_byte[3:0] : rd_byte[7:4];
            end else if (fall) begin
                LCD_D_OE  <= 1'b0;
            end

            if (rd_last && LCD_RS) addr <= next_addr(addr, incr);

            if (accept) begin
                cnt <= EXEC_LD;
                if (wr.rs) begin
                    if (ram_hit(addr)) ddram[ram_idx(addr)] <= wr.data;
                    addr <= next_addr(addr, incr);
                end else if (wr.data[7]) begin
                    addr <= wr.data[6:0];
                end else if (wr.data[6:5] == 2'b01) begin
                    mode4bit <= ~wr.data[4];
                    ptr_low  <= 1'b0;
                end else if (wr.data[6:3] == 4'b0001) begin
                    display_on <= wr.data[2];
                end else if (wr.data[6:2] == 5'b00001) begin
                    incr <= wr.data[1];
                end else if (wr.data[6:1] == 6'b000001) begin
                    addr <= 7'h00;
                    cnt  <= CLEAR_LD;
                end else if (wr.data[6:0] == 7'h01) begin
                    for (int i = 0; i < 2*LINE_BYTES; i++) ddram[i] <= SPACE;
                    addr <= 7'h00;
                    incr <= 1'b1;
                    cnt  <= CLEAR_LD;
                end
                // cursor shift / CGRAM address: only the busy period
            end
        end
    end

    for (genvar i = 0; i < LINE_LENGTH; i++) begin : g_line
        assign line1[8*(LINE_LENGTH-i) -: 8] = ddram[i];
        assign line2[8*(LINE_LENGTH-i) -: 8] = ddram[LINE_BYTES+i];
    end

endmodule
